regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb.sv | 111 +++++++++++
 tb/tb_regfile_wb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_wb                                                        |
// | Desc   : 15-entry register file, dual E/M write-back, sequential dump FSM  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_wb #(
  parameter int WORD = 64,
  parameter int NREG = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      srcA,
  input  logic [3:0]      srcB,
  input  logic [3:0]      dstE,
  input  logic [3:0]      dstM,
  input  logic [WORD-1:0] valE,
  input  logic [WORD-1:0] valM,
  input  logic            wb_en,
  output logic [WORD-1:0] valA,
  output logic [WORD-1:0] valB,
  input  logic            dump_req,
  output logic            dump_busy,
  output logic            dump_valid,
  output logic [3:0]      dump_idx,
  output logic [WORD-1:0] dump_data,
  output logic            dump_done
);

  localparam logic [3:0] C_LAST = 4'(NREG - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DUMP = 1'b1
  } state_t;

  logic [WORD-1:0] w_regs [NREG];
  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_done;
  logic            w_busy;

  // M port is checked first so it wins when both ports target one register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [3:0] C_IDX = 4'(gi);
      logic [WORD-1:0] r_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_q <= '0;
        end else if (wb_en && (dstM == C_IDX)) begin
          r_q <= valM;
        end else if (wb_en && (dstE == C_IDX)) begin
          r_q <= valE;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_state <= S_DUMP;
            r_cnt   <= '0;
          end
        end
        S_DUMP: begin
          if (r_cnt == C_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_busy     = (r_state == S_DUMP);
  assign dump_busy  = w_busy;
  assign dump_valid = w_busy;
  assign dump_idx   = w_busy ? r_cnt : 4'd0;
  assign dump_done  = r_done;

  // Indices at or beyond NREG (including 0xF) read as zero.
  always_comb begin
    valA      = '0;
    valB      = '0;
    dump_data = '0;
    if (!reset && (32'(srcA) < NREG)) valA = w_regs[srcA];
    if (!reset && (32'(srcB) < NREG)) valB = w_regs[srcB];
    if (w_busy && (32'(r_cnt) < NREG)) dump_data = w_regs[r_cnt];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_regfile_wb                                                     |
// | Desc   : table-driven read/write vectors plus directed dump/reset sequences |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_regfile_wb;

  localparam int WORD = 64;
  localparam int NREG = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      srcA, srcB, dstE, dstM;
  logic [WORD-1:0] valE, valM;
  logic            wb_en;
  logic [WORD-1:0] valA, valB;
  logic            dump_req;
  logic            dump_busy, dump_valid, dump_done;
  logic [3:0]      dump_idx;
  logic [WORD-1:0] dump_data;

  regfile_wb #(.WORD(WORD), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .wb_en(wb_en),
    .valA(valA), .valB(valB),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sa, sb, de, dm;
    logic        we;
    logic [63:0] ve, vm, ea, eb;
  } vec_t;

  vec_t        vecs [10];
  logic [63:0] exp_reg [NREG];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] sa, input logic [3:0] sb, input logic we,
                              input logic [3:0] de, input logic [63:0] ve,
                              input logic [3:0] dm, input logic [63:0] vm,
                              input logic [63:0] ea, input logic [63:0] eb);
    vec_t v;
    v.sa = sa; v.sb = sb; v.we = we; v.de = de; v.ve = ve;
    v.dm = dm; v.vm = vm; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  // Checks NREG dump cycles; caller is positioned just after the negedge of idx 0.
  task automatic dump_pass(input string tag, input bit poke);
    for (int i = 0; i < NREG; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check({tag, "_valid"}, 64'(dump_valid), 64'd1);
      check({tag, "_busy"},  64'(dump_busy),  64'd1);
      check({tag, "_idx"},   64'(dump_idx),   64'(i));
      check({tag, "_data"},  dump_data,       exp_reg[i]);
      check({tag, "_done"},  64'(dump_done),  64'd0);
      if (poke) begin
        if (i == 3) begin
          wb_en = 1'b1; dstE = 4'd10; valE = 64'h555; dstM = 4'hF;
          exp_reg[10] = 64'h555;
        end
        if (i == 4) begin
          wb_en = 1'b0; dstE = 4'hF;
        end
        if (i == 7) dump_req = 1'b1;
        if (i == 8) dump_req = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = mk(4'h3, 4'hF, 1'b0, 4'hF, 64'h0,    4'hF, 64'h0,    64'h0,    64'h0);
    vecs[1] = mk(4'h2, 4'h5, 1'b1, 4'h2, 64'h1111, 4'h5, 64'h2222, 64'h0,    64'h0);
    vecs[2] = mk(4'h2, 4'h5, 1'b0, 4'h4, 64'hAA,   4'h4, 64'hBB,   64'h1111, 64'h2222);
    vecs[3] = mk(4'h4, 4'h2, 1'b1, 4'h4, 64'hAA,   4'h4, 64'hBB,   64'h0,    64'h1111);
    vecs[4] = mk(4'h4, 4'hF, 1'b1, 4'hF, 64'h3333, 4'hF, 64'h4444, 64'hBB,   64'h0);
    vecs[5] = mk(4'h4, 4'h5, 1'b0, 4'hF, 64'h0,    4'hF, 64'h0,    64'hBB,   64'h2222);
    vecs[6] = mk(4'h0, 4'hE, 1'b1, 4'h0, 64'hDEAD, 4'hE, 64'hBEEF, 64'h0,    64'h0);
    vecs[7] = mk(4'h0, 4'hE, 1'b0, 4'hF, 64'h0,    4'hF, 64'h0,    64'hDEAD, 64'hBEEF);
    vecs[8] = mk(4'h3, 4'h4, 1'b1, 4'h3, 64'h77,   4'hF, 64'h0,    64'h0,    64'hBB);
    vecs[9] = mk(4'h3, 4'hF, 1'b0, 4'hF, 64'h0,    4'hF, 64'h0,    64'h77,   64'h0);

    reset = 1'b1; wb_en = 1'b0; dump_req = 1'b0;
    srcA = 4'h3; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(dump_busy), 64'd0);
    check("rst_done", 64'(dump_done), 64'd0);
    check("rst_valA", valA, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      srcA = vecs[i].sa; srcB = vecs[i].sb; wb_en = vecs[i].we;
      dstE = vecs[i].de; valE = vecs[i].ve; dstM = vecs[i].dm; valM = vecs[i].vm;
      #1;
      check($sformatf("vec%0d_valA", i), valA, vecs[i].ea);
      check($sformatf("vec%0d_valB", i), valB, vecs[i].eb);
    end

    // Preload reg[i] = 0x100 + i through the E port only.
    for (int k = 0; k < NREG; k++) begin
      @(negedge clk);
      wb_en = 1'b1; dstE = 4'(k); valE = 64'h100 + 64'(k); dstM = 4'hF;
      exp_reg[k] = 64'h100 + 64'(k);
    end
    @(negedge clk);
    wb_en = 1'b0; dstE = 4'hF;
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    dump_pass("dump1", 1'b1);

    @(negedge clk); #1;
    check("d1_done",      64'(dump_done),  64'd1);
    check("d1_done_busy", 64'(dump_busy),  64'd0);
    check("d1_done_vld",  64'(dump_valid), 64'd0);
    check("d1_done_idx",  64'(dump_idx),   64'd0);
    check("d1_done_data", dump_data,       64'h0);
    @(negedge clk); #1;
    check("d1_after_done", 64'(dump_done), 64'd0);
    check("d1_after_busy", 64'(dump_busy), 64'd0);

    // Held request: back-to-back dumps.
    dump_req = 1'b1;
    @(negedge clk);
    dump_pass("dump2", 1'b0);
    @(negedge clk); #1;
    check("d2_done",      64'(dump_done), 64'd1);
    check("d2_done_busy", 64'(dump_busy), 64'd0);
    @(negedge clk); #1;
    check("d3_restart_busy", 64'(dump_busy), 64'd1);
    check("d3_restart_idx",  64'(dump_idx),  64'd0);
    dump_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("d3_idx5", 64'(dump_idx), 64'd5);

    srcA = 4'h2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy",  64'(dump_busy),  64'd0);
    check("rst_mid_valid", 64'(dump_valid), 64'd0);
    check("rst_mid_valA",  valA,            64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      @(negedge clk);
      srcA = 4'(r); srcB = 4'(r);
      #1;
      check($sformatf("post_rst_reg%0d", r), valA, 64'h0);
      check("post_rst_no_done", 64'(dump_done), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire
